// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline chain and the hazard unit that drives its flushes.
package pipe_pkg;

   localparam int PIPE_W_DEFAULT = 32;
   localparam int PIPE_MAX_DEPTH = 32;

   // Per-stage kill mask as produced by the hazard unit (bit i targets stage i).
   typedef logic [PIPE_MAX_DEPTH-1:0] pipe_flush_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic register stage: a valid bit plus payload, ready when empty or draining downstream.
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = PIPE_W_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             dn_ready,
   input  logic             flush,
   output logic             v,
   output logic [WIDTH-1:0] d,
   output logic             ready
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             mv;

   // Flush deliberately stays out of ready so there is no flush->in_ready path.
   assign ready = !v_q | dn_ready;
   assign mv    = up_valid & ready;

   always_comb begin
      d_d = d_q;
      v_d = v_q & !dn_ready;
      if (mv) begin
         d_d = up_data;
         v_d = 1'b1;
      end
      if (flush) v_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= 1'b0;
         d_q <= RESET_VAL;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign v = v_q;
   assign d = d_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised valid/ready register chain with per-stage flush, bubble collapse and occupancy count.
module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = PIPE_W_DEFAULT,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   input  logic [DEPTH-1:0]            flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic [DEPTH-1:0]            stage_valid,
   output logic [clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = clog2(DEPTH + 1);

   // Index 0 is the chain input; index i+1 is the output of stage i.
   logic [DEPTH:0]   vld_c;
   logic [DEPTH:0]   rdy_c;
   logic [WIDTH-1:0] dat_c [DEPTH+1];
   logic [OCC_W-1:0] occ;

   assign vld_c[0]     = in_valid;
   assign dat_c[0]     = in_data;
   assign rdy_c[DEPTH] = out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .up_valid (vld_c[i]),
         .up_data  (dat_c[i]),
         .dn_ready (rdy_c[i+1]),
         .flush    (flush[i]),
         .v        (vld_c[i+1]),
         .d        (dat_c[i+1]),
         .ready    (rdy_c[i])
      );
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(stage_valid[i]);
   end

   assign in_ready    = rdy_c[0];
   assign stage_valid = vld_c[DEPTH:1];
   assign out_valid   = vld_c[DEPTH];
   assign out_data    = dat_c[DEPTH];
   assign occupancy   = occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus random soak on DEPTH 4, 1 and 7 instances.
module tb_pipe_stage_chain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset     = 1'b1;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data   = '0;
   logic [7:0]  flush_v   = '0;

   logic ir4, ov4; logic [31:0] od4; logic [3:0] sv4; logic [2:0] oc4;
   logic ir1, ov1; logic [31:0] od1; logic [0:0] sv1; logic [0:0] oc1;
   logic ir7, ov7; logic [31:0] od7; logic [6:0] sv7; logic [2:0] oc7;

   pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'hDEAD)) u_d4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
      .flush(flush_v[3:0]), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
      .stage_valid(sv4), .occupancy(oc4));

   pipe_stage_chain #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'h1111)) u_d1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
      .flush(flush_v[0:0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .stage_valid(sv1), .occupancy(oc1));

   pipe_stage_chain #(.WIDTH(32), .DEPTH(7), .RESET_VAL(32'h7777)) u_d7 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir7), .in_data(in_data),
      .flush(flush_v[6:0]), .out_valid(ov7), .out_ready(out_ready), .out_data(od7),
      .stage_valid(sv7), .occupancy(oc7));

   int total = 0;
   int bad   = 0;

   // Reference model: slot k,i holds an item (mv) with value md; slot DEPTH-1 is the output end.
   bit          mv [3][8];
   logic [31:0] md [3][8];
   int          dep [3] = '{4, 1, 7};
   logic [31:0] rv  [3] = '{32'hDEAD, 32'h1111, 32'h7777};
   bit          mdl_ok = 1'b0;

   logic [31:0] got[$];
   bit          last_acc = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_inst(input int k);
      int          D;
      bit          take [9];
      logic [7:0]  e_sv, o_sv;
      int          e_occ;
      logic        o_ir, o_ov, src_v;
      logic [31:0] o_od, o_oc, src_d;
      D = dep[k];
      case (k)
         0:       begin o_ir = ir4; o_ov = ov4; o_od = od4; o_sv = 8'(sv4); o_oc = 32'(oc4); end
         1:       begin o_ir = ir1; o_ov = ov1; o_od = od1; o_sv = 8'(sv1); o_oc = 32'(oc1); end
         default: begin o_ir = ir7; o_ov = ov7; o_od = od7; o_sv = 8'(sv7); o_oc = 32'(oc7); end
      endcase
      // A slot can take an item if it is empty or its occupant leaves this cycle.
      take[D] = out_ready;
      for (int i = D - 1; i >= 0; i--) take[i] = !mv[k][i] || take[i+1];
      e_sv  = '0;
      e_occ = 0;
      for (int i = 0; i < D; i++) begin
         e_sv[i] = mv[k][i];
         e_occ  += int'(mv[k][i]);
      end
      if (mdl_ok) begin
         chk($sformatf("d%0d_in_ready", D),    32'(o_ir), 32'(take[0]));
         chk($sformatf("d%0d_out_valid", D),   32'(o_ov), 32'(mv[k][D-1]));
         chk($sformatf("d%0d_out_data", D),    o_od,      md[k][D-1]);
         chk($sformatf("d%0d_stage_valid", D), 32'(o_sv), 32'(e_sv));
         chk($sformatf("d%0d_occupancy", D),   o_oc,      32'(e_occ));
      end
      if (reset) begin
         for (int i = 0; i < D; i++) begin mv[k][i] = 1'b0; md[k][i] = rv[k]; end
      end else begin
         for (int i = D - 1; i >= 0; i--) begin
            src_v = (i == 0) ? in_valid : mv[k][i-1];
            src_d = (i == 0) ? in_data  : md[k][i-1];
            if (src_v && take[i]) begin
               mv[k][i] = 1'b1;
               md[k][i] = src_d;
            end else if (take[i+1]) begin
               mv[k][i] = 1'b0;
            end
            if (flush_v[i]) mv[k][i] = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      last_acc = in_valid && ir4;
      if (ov4 && out_ready) got.push_back(od4);
      for (int k = 0; k < 3; k++) model_inst(k);
      if (reset) mdl_ok = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int item, n_acc;
      logic [31:0] a_data;

      // T1 reset
      reset = 1'b1;
      cyc(); cyc();
      chk("t1_stage_valid", 32'(sv4), 32'h0);
      chk("t1_out_data",    od4,      32'hDEAD);
      chk("t1_occupancy",   32'(oc4), 32'h0);
      chk("t1_in_ready",    32'(ir4), 32'h1);
      reset = 1'b0;

      // T2 streaming
      out_ready = 1'b1;
      got.delete();
      for (int c = 1; c <= 8; c++) begin
         in_valid = (c <= 5);
         in_data  = c;
         cyc();
         if (c == 3) chk("t2_no_early_valid", 32'(ov4), 32'h0);
         if (c >= 4) begin
            chk("t2_out_valid", 32'(ov4), 32'h1);
            chk("t2_out_data",  od4,      32'(c - 3));
         end
      end
      idle(2);
      chk("t2_count", 32'(got.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk("t2_order", got[i], 32'(i + 1));

      // T3 backpressure
      out_ready = 1'b0;
      item  = 1;
      n_acc = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = (item <= 6);
         in_data  = item;
         cyc();
         if (last_acc) begin
            item++;
            n_acc++;
            if (n_acc == 4) begin
               chk("t3_in_ready_full", 32'(ir4), 32'h0);
               chk("t3_occ_full",      32'(oc4), 32'd4);
            end
         end
      end
      chk("t3_accepted", 32'(n_acc), 32'd4);
      got.delete();
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         in_valid = (item <= 6);
         in_data  = item;
         cyc();
         if (last_acc) item++;
      end
      in_valid = 1'b0;
      chk("t3_count", 32'(got.size()), 32'd6);
      for (int i = 0; i < 6; i++) chk("t3_order", got[i], 32'(i + 1));

      // T4 bubble collapse
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h1; cyc();
      idle(2);
      in_valid = 1'b1; in_data = 32'h2; cyc();
      idle(4);
      chk("t4_stage_valid", 32'(sv4), 32'hC);
      chk("t4_out_data",    od4,      32'h1);
      chk("t4_occupancy",   32'(oc4), 32'd2);
      out_ready = 1'b1;
      idle(4);

      // T5 flush of the middle stages while the tail drains
      out_ready = 1'b0;
      got.delete();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hA + i;
         cyc();
      end
      in_valid  = 1'b0;
      flush_v   = 8'b0000_0110;
      out_ready = 1'b1;
      cyc();
      flush_v = '0;
      chk("t5_stage_valid", 32'(sv4), 32'h8);
      chk("t5_out_data",    od4,      32'hB);
      chk("t5_occupancy",   32'(oc4), 32'd1);
      cyc();
      chk("t5_empty", 32'(sv4), 32'h0);
      chk("t5_count", 32'(got.size()), 32'd2);
      chk("t5_first", got[0], 32'hA);
      chk("t5_second", got[1], 32'hB);

      // T6 reset with a full chain
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h60 + i;
         cyc();
      end
      for (int i = 0; i < 2; i++) begin
         out_ready = (i == 0);
         in_data   = 32'h70 + i;
         cyc();
      end
      reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h99;
      cyc();
      reset = 1'b0;
      chk("t6_stage_valid", 32'(sv4), 32'h0);
      chk("t6_out_valid",   32'(ov4), 32'h0);
      chk("t6_occupancy",   32'(oc4), 32'h0);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         out_ready = 1'(($urandom() & 1));
         cyc();
         chk("t6_no_pulse", 32'(ov4), 32'h0);
      end

      // Random soak; the model tracks every instance each cycle
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         if (!(in_valid && !last_acc)) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = $urandom();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         for (int b = 0; b < 8; b++) flush_v[b] = ($urandom_range(0, 9) == 0);
         cyc();
      end
      reset = 1'b0; flush_v = '0; in_valid = 1'b0; out_ready = 1'b1;
      cyc(); cyc();
      a_data = od4;
      chk("soak_drained", 32'(ov4), 32'h0);
      chk("soak_hold_data", od4, a_data);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
